// File: rtl/memoreer_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memoreer_unit_if : issue, data-RAM and writeback bundle of the load/store unit
// Revision 1.0
// ---------------------------------------------------------------------------
interface memoreer_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 3
);
  // scoreboard issue
  logic              issue_valid;
  logic              issue_op;
  logic [REG_AW-1:0] issue_dest;
  logic [DATA_W-1:0] issue_base;
  logic [DATA_W-1:0] issue_offset;
  logic [DATA_W-1:0] issue_data;
  logic              busy;
  // data RAM
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  // register-file writeback
  logic              wb_req;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic              wb_grant;
  logic              store_done;

  // master: scoreboard / RAM / register-file side
  modport master (
    output issue_valid, issue_op, issue_dest, issue_base, issue_offset, issue_data,
    output mem_rdata, wb_grant,
    input  busy, mem_addr, mem_wdata, mem_we, wb_req, wb_dest, wb_value, store_done
  );

  // slave: the memory functional unit itself
  modport slave (
    input  issue_valid, issue_op, issue_dest, issue_base, issue_offset, issue_data,
    input  mem_rdata, wb_grant,
    output busy, mem_addr, mem_wdata, mem_we, wb_req, wb_dest, wb_value, store_done
  );
endinterface
`default_nettype wire

// File: rtl/memoreer_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memoreer_unit : single-op load/store unit (MEMOREER_0) of the c16 core
// Revision 1.0
// ---------------------------------------------------------------------------
module memoreer_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_AW      = 3,
  parameter int MEM_LATENCY = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  memoreer_unit_if.slave  bus
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_wait   = 2'd2;
  localparam logic [1:0] c_st_wb     = 2'd3;

  localparam logic              c_op_store = 1'b1;
  localparam logic [1:0]        c_lat_last = 2'(MEM_LATENCY - 1);
  localparam logic [REG_AW-1:0] c_reg_r7   = REG_AW'(7);

  logic [1:0]        r_state;
  logic              r_op;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_cnt;
  logic [REG_AW-1:0] r_wb_dest;
  logic [DATA_W-1:0] r_wb_value;

  logic [DATA_W-1:0] w_sum;

  // Carry out of the address add is discarded.
  assign w_sum = bus.issue_base + bus.issue_offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_op       <= 1'b0;
      r_dest     <= '0;
      r_data     <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_wb_dest  <= '0;
      r_wb_value <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (bus.issue_valid) begin
            r_op    <= bus.issue_op;
            r_dest  <= bus.issue_dest;
            r_data  <= bus.issue_data;
            r_addr  <= ADDR_W'(w_sum);
            r_state <= c_st_access;
          end
        end
        c_st_access: begin
          if (r_op == c_op_store) begin
            r_state <= c_st_idle;
          end else begin
            r_cnt   <= c_lat_last;
            r_state <= c_st_wait;
          end
        end
        c_st_wait: begin
          if (r_cnt == 2'd0) begin
            r_wb_value <= bus.mem_rdata;
            r_wb_dest  <= r_dest;
            // r7 is hard-wired, so a load into it is simply dropped.
            r_state    <= (r_dest == c_reg_r7) ? c_st_idle : c_st_wb;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        c_st_wb: begin
          if (bus.wb_grant) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.busy       = (r_state != c_st_idle);
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_data;
  assign bus.mem_we     = (r_state == c_st_access) && (r_op == c_op_store);
  assign bus.store_done = (r_state == c_st_access) && (r_op == c_op_store);
  assign bus.wb_req     = (r_state == c_st_wb);
  assign bus.wb_dest    = r_wb_dest;
  assign bus.wb_value   = r_wb_value;

endmodule
`default_nettype wire
